// File: rtl/downmix_pkg.sv
// downmix_pkg: shared mode/state encodings and error counter width for the downmixer.
package downmix_pkg;
    localparam int ERR_W = 8;
    typedef enum logic [1:0] {
        MODE_SELECT = 2'd0,
        MODE_AVG    = 2'd1,
        MODE_SUM    = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;
    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        OUTPUT = 2'd1,
        RESYNC = 2'd2
    } state_t;
endpackage

// File: rtl/sample_saturator.sv
// sample_saturator: clamps a wide signed accumulator into the signed SAMPLE_WIDTH range.
module sample_saturator #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int ACC_WIDTH    = 25
) (
    input  logic signed [ACC_WIDTH-1:0]    acc_i,
    output logic signed [SAMPLE_WIDTH-1:0] sample_o
);
    localparam logic signed [ACC_WIDTH-1:0] MAX = {{(ACC_WIDTH-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN = ~MAX;
    always_comb sample_o = acc_i > MAX ? MAX[SAMPLE_WIDTH-1:0] :
                           acc_i < MIN ? MIN[SAMPLE_WIDTH-1:0] : acc_i[SAMPLE_WIDTH-1:0];
endmodule

// File: rtl/axis_multichannel_downmixer.sv
// axis_multichannel_downmixer: folds NUM_CHANNELS AXIS beats per frame into one
// output sample (select / average / saturating sum) with framing-error recovery.
module axis_multichannel_downmixer
    import downmix_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 24,
    parameter int NUM_CHANNELS = 2
) (
    input  logic                            AXIS_ACLK,
    input  logic                            AXIS_ARESET,
    input  logic [DATA_WIDTH-1:0]           S_AXIS_TDATA,
    input  logic                            S_AXIS_TVALID,
    input  logic                            S_AXIS_TLAST,
    output logic                            S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0]           M_AXIS_TDATA,
    output logic                            M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY,
    input  logic [1:0]                      mode,
    input  logic [$clog2(NUM_CHANNELS)-1:0] sel_channel,
    output logic                            frame_error,
    output logic [ERR_W-1:0]                error_count
);
    localparam int LOG2N = $clog2(NUM_CHANNELS);
    localparam int AW    = SAMPLE_WIDTH + LOG2N;

    if (!(NUM_CHANNELS == 2 || NUM_CHANNELS == 4 || NUM_CHANNELS == 8) || SAMPLE_WIDTH > DATA_WIDTH) begin : g_bad_params
        $error("axis_multichannel_downmixer: NUM_CHANNELS must be 2, 4 or 8 and SAMPLE_WIDTH <= DATA_WIDTH");
    end

    state_t                    state_q, state_d;
    mode_t                     mode_q, mode_d, mode_eff;
    logic [LOG2N-1:0]          cnt_q, cnt_d, sel_q, sel_d, sel_eff;
    logic signed [AW-1:0]      acc_q, acc_d, acc_sum, avg;
    logic signed [SAMPLE_WIDTH-1:0] sample, pick_q, pick_d, pick_next, sat, result;
    logic [DATA_WIDTH-1:0]     tdata_q, tdata_d, result_slot;
    logic                      tvalid_q, tvalid_d, err;
    logic [ERR_W-1:0]          ecnt_q, ecnt_d;
    logic                      ferr_q, beat, first, last_cnt;

    assign sample    = S_AXIS_TDATA[DATA_WIDTH-1 -: SAMPLE_WIDTH];
    assign beat      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign first     = cnt_q == '0;
    assign last_cnt  = cnt_q == LOG2N'(NUM_CHANNELS - 1);
    // controls are sampled on the first beat so a frame is processed with one consistent setting
    assign mode_eff  = first ? mode_t'(mode) : mode_q;
    assign sel_eff   = first ? sel_channel : sel_q;
    assign pick_next = cnt_q == sel_eff ? sample : pick_q;
    assign acc_sum   = acc_q + {{LOG2N{sample[SAMPLE_WIDTH-1]}}, sample};
    assign avg       = acc_sum >>> LOG2N;
    assign result    = mode_q == MODE_SELECT ? pick_next :
                       mode_q == MODE_SUM    ? sat : avg[SAMPLE_WIDTH-1:0];
    assign result_slot = DATA_WIDTH'(unsigned'(result)) << (DATA_WIDTH - SAMPLE_WIDTH);

    sample_saturator #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ACC_WIDTH(AW)) u_sat (
        .acc_i    (acc_sum),
        .sample_o (sat)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        pick_d   = pick_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        err      = 1'b0;
        if (state_q == ACCUM && beat) begin
            mode_d = mode_eff;
            sel_d  = sel_eff;
            pick_d = pick_next;
            cnt_d  = cnt_q + 1'b1;
            acc_d  = acc_sum;
            if (S_AXIS_TLAST || last_cnt) begin
                cnt_d = '0;
                acc_d = '0;
                err   = !(S_AXIS_TLAST && last_cnt);
                if (S_AXIS_TLAST && last_cnt) begin
                    tvalid_d = 1'b1;
                    tdata_d  = result_slot;
                    state_d  = OUTPUT;
                end else if (!S_AXIS_TLAST) begin
                    state_d = RESYNC;
                end
            end
        end else if (state_q == OUTPUT && M_AXIS_TREADY) begin
            tvalid_d = 1'b0;
            state_d  = ACCUM;
        end else if (state_q == RESYNC && beat && S_AXIS_TLAST) begin
            state_d = ACCUM;
        end
        ecnt_d = err && ecnt_q != '1 ? ecnt_q + 1'b1 : ecnt_q;
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q  <= ACCUM;
            mode_q   <= MODE_AVG;
            sel_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            pick_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            ferr_q   <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            pick_q   <= pick_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            ferr_q   <= err;
            ecnt_q   <= ecnt_d;
        end
    end

    assign S_AXIS_TREADY = !AXIS_ARESET && state_q != OUTPUT;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign frame_error   = ferr_q;
    assign error_count   = ecnt_q;
endmodule

// File: tb/tb_axis_multichannel_downmixer.sv
// tb_axis_multichannel_downmixer: directed checks of a 2-channel and a 4-channel downmixer.
module tb_axis_multichannel_downmixer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_data2 = '0, s_data4 = '0, m_data2, m_data4;
    logic        s_valid2 = 1'b0, s_last2 = 1'b0, s_ready2, m_valid2, m_last2, m_ready2 = 1'b0;
    logic        s_valid4 = 1'b0, s_last4 = 1'b0, s_ready4, m_valid4, m_last4, m_ready4 = 1'b0;
    logic [1:0]  mode2 = 2'd1, mode4 = 2'd0;
    logic        sel2 = 1'b0;
    logic [1:0]  sel4 = 2'd1;
    logic        ferr2, ferr4;
    logic [7:0]  ecnt2, ecnt4;
    logic [31:0] held;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    axis_multichannel_downmixer #(.NUM_CHANNELS(2)) dut2 (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S_AXIS_TDATA(s_data2), .S_AXIS_TVALID(s_valid2), .S_AXIS_TLAST(s_last2), .S_AXIS_TREADY(s_ready2),
        .M_AXIS_TDATA(m_data2), .M_AXIS_TVALID(m_valid2), .M_AXIS_TLAST(m_last2), .M_AXIS_TREADY(m_ready2),
        .mode(mode2), .sel_channel(sel2), .frame_error(ferr2), .error_count(ecnt2)
    );

    axis_multichannel_downmixer #(.NUM_CHANNELS(4)) dut4 (
        .AXIS_ACLK(clk), .AXIS_ARESET(rst),
        .S_AXIS_TDATA(s_data4), .S_AXIS_TVALID(s_valid4), .S_AXIS_TLAST(s_last4), .S_AXIS_TREADY(s_ready4),
        .M_AXIS_TDATA(m_data4), .M_AXIS_TVALID(m_valid4), .M_AXIS_TLAST(m_last4), .M_AXIS_TREADY(m_ready4),
        .mode(mode4), .sel_channel(sel4), .frame_error(ferr4), .error_count(ecnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input bit four, input logic [31:0] d, input bit last);
        if (four) begin s_data4 = d; s_last4 = last; s_valid4 = 1'b1; end
        else begin s_data2 = d; s_last2 = last; s_valid2 = 1'b1; end
        @(posedge clk);
        #1;
        s_valid2 = 1'b0;
        s_valid4 = 1'b0;
    endtask

    task automatic handshake(input bit four, input string tag);
        if (four) m_ready4 = 1'b1; else m_ready2 = 1'b1;
        @(posedge clk);
        #1;
        m_ready2 = 1'b0;
        m_ready4 = 1'b0;
        chk({tag, "_valid_drop"}, four ? m_valid4 : m_valid2, 0);
        chk({tag, "_sready_back"}, four ? s_ready4 : s_ready2, 1);
    endtask

    task automatic frame2(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        beat(0, a, 0);
        chk({tag, "_no_early_valid"}, m_valid2, 0);
        beat(0, b, 1);
        chk({tag, "_valid"}, m_valid2, 1);
        chk({tag, "_last"}, m_last2, 1);
        chk({tag, "_data"}, m_data2, exp);
        chk({tag, "_sready_low"}, s_ready2, 0);
        handshake(0, tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sready", s_ready2, 0);
        chk("rst_mvalid", m_valid2, 0);
        chk("rst_mdata", m_data2, 0);
        chk("rst_mlast", m_last2, 0);
        chk("rst_ferr", ferr2, 0);
        chk("rst_ecnt", ecnt2, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_sready", s_ready2, 1);

        mode2 = 2'd1;
        frame2("avg", 32'h0001_0000, 32'h0003_0000, 32'h0002_0000);
        frame2("avg_floor", 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00);
        mode2 = 2'd3;
        frame2("rsvd_avg", 32'h0000_0500, 32'h0000_0200, 32'h0000_0300);
        mode2 = 2'd2;
        frame2("sum_pos", 32'h7FFF_FF00, 32'h0000_0100, 32'h7FFF_FF00);
        frame2("sum_neg", 32'h8000_0000, 32'hFFFF_FF00, 32'h8000_0000);
        frame2("sum_mid", 32'h0000_1000, 32'hFFFF_F800, 32'h0000_0800);
        mode2 = 2'd0;
        sel2 = 1'b0;
        frame2("sel0", 32'h0000_1100, 32'h0000_2200, 32'h0000_1100);
        sel2 = 1'b1;
        frame2("sel1", 32'h0000_1100, 32'h0000_2200, 32'h0000_2200);

        mode2 = 2'd1;
        beat(0, 32'h0001_0000, 1);
        chk("early_ferr", ferr2, 1);
        chk("early_ecnt", ecnt2, 1);
        chk("early_novalid", m_valid2, 0);
        @(posedge clk);
        #1;
        chk("early_ferr_pulse", ferr2, 0);
        frame2("after_early", 32'h0001_0000, 32'h0003_0000, 32'h0002_0000);

        beat(0, 32'h0011_0000, 0);
        beat(0, 32'h0022_0000, 0);
        chk("miss_ferr", ferr2, 1);
        chk("miss_ecnt", ecnt2, 2);
        chk("miss_novalid", m_valid2, 0);
        beat(0, 32'h0100_0000, 0);
        chk("resync_noerr", ferr2, 0);
        beat(0, 32'h0200_0000, 0);
        beat(0, 32'h0300_0000, 1);
        chk("resync_novalid", m_valid2, 0);
        chk("resync_ecnt", ecnt2, 2);
        beat(0, 32'h0002_0000, 0);
        beat(0, 32'h0004_0000, 1);
        chk("post_resync_data", m_data2, 32'h0003_0000);
        held = m_data2;
        for (int i = 0; i < 5; i++) begin
            s_data2 = 32'h5555_0000 + 32'(i);
            s_valid2 = 1'b1;
            @(posedge clk);
            #1;
            chk("stall_data", m_data2, held);
            chk("stall_valid", m_valid2, 1);
            chk("stall_sready", s_ready2, 0);
        end
        s_valid2 = 1'b0;
        handshake(0, "stall");
        chk("stall_ecnt", ecnt2, 2);

        beat(0, 32'h0100_0000, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_sready", s_ready2, 0);
        chk("mid_rst_ecnt", ecnt2, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rel_sready", s_ready2, 1);
        frame2("post_rst", 32'h0002_0000, 32'h0004_0000, 32'h0003_0000);
        beat(0, 32'h0002_0000, 0);
        beat(0, 32'h0004_0000, 1);
        chk("out_rst_pre", m_valid2, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("out_rst_valid", m_valid2, 0);
        chk("out_rst_data", m_data2, 0);
        chk("out_rst_last", m_last2, 0);

        mode4 = 2'd0;
        sel4 = 2'd1;
        beat(1, 32'h0000_0100, 0);
        beat(1, 32'h0000_0200, 0);
        beat(1, 32'h0000_0300, 0);
        chk("n4_no_early_valid", m_valid4, 0);
        beat(1, 32'h0000_0400, 1);
        chk("n4_sel_valid", m_valid4, 1);
        chk("n4_sel_data", m_data4, 32'h0000_0200);
        handshake(1, "n4_sel");
        beat(1, 32'h0000_0100, 0);
        sel4 = 2'd3;
        beat(1, 32'h0000_0200, 0);
        beat(1, 32'h0000_0300, 0);
        beat(1, 32'h0000_0400, 1);
        chk("n4_selmid_data", m_data4, 32'h0000_0200);
        handshake(1, "n4_selmid");
        mode4 = 2'd1;
        beat(1, 32'h0000_0100, 0);
        beat(1, 32'h0000_0200, 0);
        beat(1, 32'h0000_0300, 0);
        beat(1, 32'h0000_0600, 1);
        chk("n4_avg_data", m_data4, 32'h0000_0300);
        handshake(1, "n4_avg");
        chk("n4_ecnt", ecnt4, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
